// File: rtl/dmem_arb_pkg.sv
// Shared types and defaults for the data-memory arbiter between the core
// load/store path and the external loader/debug port.
package dmem_arb_pkg;

    typedef enum logic {
        ARB_IDLE      = 1'b0,
        ARB_EXT_BURST = 1'b1
    } arb_state_t;

    localparam int DEF_AW        = 8;
    localparam int DEF_DW        = 8;
    localparam int DEF_MAX_WAIT  = 4;
    localparam int DEF_MAX_BURST = 8;

    // Bits needed to hold 0..limit; never narrower than one bit.
    function automatic int cnt_width(input int limit);
        return (limit < 1) ? 1 : $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bus bundle for the arbiter: core port, ext port and the single memory port.
// slave = arbiter view, master = surrounding core/ext/memory view.
interface dmem_arbiter_if
    import dmem_arb_pkg::*;
#(
    parameter int AW = DEF_AW,
    parameter int DW = DEF_DW
);
    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic          cpu_stall;
    logic [DW-1:0] cpu_rdata;

    logic          ext_req;
    logic          ext_we;
    logic          ext_lock;
    logic [AW-1:0] ext_addr;
    logic [DW-1:0] ext_wdata;
    logic          ext_gnt;
    logic [DW-1:0] ext_rdata;
    logic          ext_rvalid;

    logic          mem_wr_en;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_dat_in;
    logic [DW-1:0] mem_dat_out;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_stall, cpu_rdata,
        input  ext_req, ext_we, ext_lock, ext_addr, ext_wdata,
        output ext_gnt, ext_rdata, ext_rvalid,
        output mem_wr_en, mem_addr, mem_dat_in,
        input  mem_dat_out
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_stall, cpu_rdata,
        output ext_req, ext_we, ext_lock, ext_addr, ext_wdata,
        input  ext_gnt, ext_rdata, ext_rvalid,
        input  mem_wr_en, mem_addr, mem_dat_in,
        output mem_dat_out
    );

endinterface

// File: rtl/dmem_arbiter_sat_counter.sv
// Up-counter that saturates at LIMIT; clr wins over inc, reset is synchronous.
module sat_counter #(
    parameter int WIDTH = 4,
    parameter int LIMIT = 15
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] count,
    output logic             at_max
);

    localparam logic [WIDTH-1:0] LIM = WIDTH'(LIMIT);

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            count <= '0;
        end else if (inc && (count != LIM)) begin
            count <= count + WIDTH'(1);
        end
    end

    assign at_max = (count == LIM);

endmodule

// File: rtl/dmem_arbiter.sv
// Single-port data-memory arbiter: core vs ext, one access per cycle, with
// ext starvation guard and bounded locked bursts.
//
// state          | meaning
// ST_IDLE        | normal arbitration, core wins unless ext has waited MAX_WAIT
// ST_BURST       | ext owns memory for a locked run of up to MAX_BURST beats
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int AW        = DEF_AW,
    parameter int DW        = DEF_DW,
    parameter int MAX_WAIT  = DEF_MAX_WAIT,
    parameter int MAX_BURST = DEF_MAX_BURST
) (
    input  logic          clk,
    input  logic          reset,
    dmem_arbiter_if.slave bus
);

    localparam logic [0:0] ST_IDLE  = 1'(ARB_IDLE);
    localparam logic [0:0] ST_BURST = 1'(ARB_EXT_BURST);

    localparam int  WW       = cnt_width(MAX_WAIT);
    localparam int  BW       = cnt_width(MAX_BURST - 1);
    localparam bit  BURST_EN = (MAX_BURST > 1);

    logic [0:0]    state;
    logic [WW-1:0] wait_cnt;
    logic          wait_max;
    logic [BW-1:0] burst_cnt;
    logic          burst_max;

    logic          ext_gnt_c;
    logic          cpu_gnt_c;
    logic          burst_enter;
    logic          burst_exit;
    logic          burst_inc;
    logic          wait_clr;

    logic [DW-1:0] ext_rdata_q;
    logic          ext_rvalid_q;

    logic          mem_wr_en_c;
    logic [AW-1:0] mem_addr_c;
    logic [DW-1:0] mem_dat_c;

    // Grants are suppressed while reset is held so nothing reaches memory.
    always_comb begin
        ext_gnt_c = 1'b0;
        if (!reset) begin
            if (state == ST_BURST) begin
                ext_gnt_c = bus.ext_req;
            end else begin
                ext_gnt_c = bus.ext_req & (~bus.cpu_req | wait_max);
            end
        end
        cpu_gnt_c = ~reset & bus.cpu_req & ~ext_gnt_c;
    end

    always_comb begin
        burst_enter = (state == ST_IDLE) & ext_gnt_c & bus.ext_lock & BURST_EN;
        burst_exit  = (state == ST_BURST) &
                      (~bus.ext_req | ~bus.ext_lock | (burst_max & ext_gnt_c));
        burst_inc   = burst_enter | ((state == ST_BURST) & ~burst_exit & ext_gnt_c);
        wait_clr    = ext_gnt_c | ~bus.ext_req;
    end

    sat_counter #(
        .WIDTH (WW),
        .LIMIT (MAX_WAIT)
    ) u_wait_cnt (
        .clk    (clk),
        .reset  (reset),
        .inc    (~wait_clr),
        .clr    (wait_clr),
        .count  (wait_cnt),
        .at_max (wait_max)
    );

    sat_counter #(
        .WIDTH (BW),
        .LIMIT (MAX_BURST - 1)
    ) u_burst_cnt (
        .clk    (clk),
        .reset  (reset),
        .inc    (burst_inc),
        .clr    (burst_exit),
        .count  (burst_cnt),
        .at_max (burst_max)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else if (burst_enter) begin
            state <= ST_BURST;
        end else if (burst_exit) begin
            state <= ST_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ext_rvalid_q <= 1'b0;
            ext_rdata_q  <= '0;
        end else begin
            ext_rvalid_q <= ext_gnt_c & ~bus.ext_we;
            if (ext_gnt_c && !bus.ext_we) begin
                ext_rdata_q <= bus.mem_dat_out;
            end
        end
    end

    always_comb begin
        mem_wr_en_c = 1'b0;
        mem_addr_c  = '0;
        mem_dat_c   = '0;
        if (ext_gnt_c) begin
            mem_wr_en_c = bus.ext_we;
            mem_addr_c  = bus.ext_addr;
            mem_dat_c   = bus.ext_wdata;
        end else if (cpu_gnt_c) begin
            mem_wr_en_c = bus.cpu_we;
            mem_addr_c  = bus.cpu_addr;
            mem_dat_c   = bus.cpu_wdata;
        end
    end

    assign bus.mem_wr_en  = mem_wr_en_c;
    assign bus.mem_addr   = mem_addr_c;
    assign bus.mem_dat_in = mem_dat_c;

    assign bus.cpu_stall  = bus.cpu_req & ext_gnt_c;
    assign bus.cpu_rdata  = cpu_gnt_c ? bus.mem_dat_out : '0;

    assign bus.ext_gnt    = ext_gnt_c;
    assign bus.ext_rdata  = ext_rdata_q;
    assign bus.ext_rvalid = ext_rvalid_q;

    // Raw counts are kept for observability; decisions use the at_max flags.
    logic cnt_unused;
    assign cnt_unused = ^{wait_cnt, burst_cnt};

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed + randomized bench for dmem_arbiter against a cycle-level
// behavioural model of the arbitration rules and the memory image.
module tb_dmem_arbiter;
    import dmem_arb_pkg::*;

    localparam int MAX_WAIT  = 4;
    localparam int MAX_BURST = 8;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    dmem_arbiter_if #(.AW(8), .DW(8)) bus ();

    dmem_arbiter #(
        .AW        (8),
        .DW        (8),
        .MAX_WAIT  (MAX_WAIT),
        .MAX_BURST (MAX_BURST)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    function automatic logic [7:0] init_val(input int i);
        return 8'(i * 37 + 11);
    endfunction

    // Memory with asynchronous read, written at posedge.
    logic [7:0] mem [256];
    logic       mem_init;
    assign bus.mem_dat_out = mem[bus.mem_addr];
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 256; i++) mem[i] <= init_val(i);
        end else if (bus.mem_wr_en) begin
            mem[bus.mem_addr] <= bus.mem_dat_in;
        end
    end

    int    n_cmp  = 0;
    int    n_fail = 0;
    string phase  = "init";

    // Reference model state
    logic [7:0] ref_mem [256];
    bit         m_burst, m_known;
    int         m_wait, m_beats;
    logic       exp_rvalid;
    logic [7:0] exp_rdata;
    bit         p_eg, p_cg;
    bit         s_rst, s_creq, s_cwe, s_ereq, s_ewe, s_elock;
    logic [7:0] s_caddr, s_cwd, s_eaddr, s_ewd;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s.%s: observed 0x%0h, expected 0x%0h", phase, tag, obs, exp);
        end
    endtask

    task automatic drive(input bit rst, input bit creq, input bit cwe,
                         input logic [7:0] caddr, input logic [7:0] cwd,
                         input bit ereq, input bit ewe, input bit elock,
                         input logic [7:0] eaddr, input logic [7:0] ewd);
        logic [7:0] e_wr, e_ad, e_dt;
        reset = rst;
        bus.cpu_req = creq; bus.cpu_we = cwe; bus.cpu_addr = caddr; bus.cpu_wdata = cwd;
        bus.ext_req = ereq; bus.ext_we = ewe; bus.ext_lock = elock;
        bus.ext_addr = eaddr; bus.ext_wdata = ewd;
        s_rst = rst; s_creq = creq; s_cwe = cwe; s_caddr = caddr; s_cwd = cwd;
        s_ereq = ereq; s_ewe = ewe; s_elock = elock; s_eaddr = eaddr; s_ewd = ewd;
        #1;
        if (rst) begin
            p_eg = 1'b0;
            p_cg = 1'b0;
            check("rst_ext_gnt", bus.ext_gnt, 0);
            check("rst_cpu_stall", bus.cpu_stall, 0);
            check("rst_mem_wr_en", bus.mem_wr_en, 0);
        end else begin
            p_eg = m_burst ? ereq : (ereq && (!creq || m_wait >= MAX_WAIT));
            p_cg = creq && !p_eg;
            e_wr = p_eg ? 8'(ewe)  : (p_cg ? 8'(cwe) : 8'h00);
            e_ad = p_eg ? eaddr    : (p_cg ? caddr   : 8'h00);
            e_dt = p_eg ? ewd      : (p_cg ? cwd     : 8'h00);
            check("ext_gnt", bus.ext_gnt, p_eg);
            check("cpu_stall", bus.cpu_stall, creq && p_eg);
            check("mem_wr_en", bus.mem_wr_en, e_wr);
            check("mem_addr", bus.mem_addr, e_ad);
            check("mem_dat_in", bus.mem_dat_in, e_dt);
            check("cpu_rdata", bus.cpu_rdata, p_cg ? ref_mem[caddr] : 8'h00);
        end
        if (m_known) begin
            check("ext_rvalid", bus.ext_rvalid, exp_rvalid);
            check("ext_rdata", bus.ext_rdata, exp_rdata);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (s_rst) begin
            m_burst = 0; m_wait = 0; m_beats = 0;
            exp_rvalid = 1'b0; exp_rdata = 8'h00; m_known = 1;
        end else begin
            if (p_eg && !s_ewe) exp_rdata = ref_mem[s_eaddr];
            exp_rvalid = p_eg && !s_ewe;
            if (p_eg && s_ewe) ref_mem[s_eaddr] = s_ewd;
            else if (p_cg && s_cwe) ref_mem[s_caddr] = s_cwd;
            m_wait = (p_eg || !s_ereq) ? 0 : ((m_wait < MAX_WAIT) ? m_wait + 1 : MAX_WAIT);
            if (m_burst) begin
                if (!s_ereq || !s_elock || (p_eg && m_beats + 1 == MAX_BURST)) begin
                    m_burst = 0; m_beats = 0;
                end else if (p_eg) begin
                    m_beats++;
                end
            end else if (p_eg && s_elock && MAX_BURST > 1) begin
                m_burst = 1; m_beats = 1;
            end
        end
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int b, diffs;
        bit e_req, e_we, e_lock, last_eg, rst, creq, cwe;
        logic [7:0] e_addr, e_wd, caddr, cwd;

        for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
        m_known = 0; m_burst = 0; m_wait = 0; m_beats = 0;
        exp_rvalid = 1'b0; exp_rdata = 8'h00;
        reset = 1'b1; mem_init = 1'b1;
        bus.cpu_req = 0; bus.cpu_we = 0; bus.cpu_addr = 0; bus.cpu_wdata = 0;
        bus.ext_req = 0; bus.ext_we = 0; bus.ext_lock = 0; bus.ext_addr = 0; bus.ext_wdata = 0;
        @(negedge clk);

        phase = "reset";
        for (int i = 0; i < 2; i++) begin
            drive(1, 1, 1, 8'h10, 8'h33, 1, 1, 0, 8'h20, 8'h44);
            tick();
            mem_init = 1'b0;
        end
        check("state_after_reset", 32'(dut.state), 32'(1'(ARB_IDLE)));

        phase = "cpu_store_load";
        drive(0, 1, 1, 8'h10, 8'hA5, 0, 0, 0, 8'h00, 8'h00);
        check("st_wr_en", bus.mem_wr_en, 1);
        check("st_addr", bus.mem_addr, 8'h10);
        check("st_dat", bus.mem_dat_in, 8'hA5);
        tick();
        drive(0, 1, 0, 8'h10, 8'h00, 0, 0, 0, 8'h00, 8'h00);
        check("ld_rdata", bus.cpu_rdata, 8'hA5);
        check("ld_stall", bus.cpu_stall, 0);
        tick();

        phase = "contention";
        for (int c = 1; c <= 5; c++) begin
            drive(0, 1, 0, 8'h30, 8'h00, 1, 0, 0, 8'h20, 8'h00);
            check("ct_gnt", bus.ext_gnt, (c == 5));
            check("ct_stall", bus.cpu_stall, (c == 5));
            tick();
        end
        drive(0, 1, 0, 8'h30, 8'h00, 0, 0, 0, 8'h00, 8'h00);
        check("ct_rvalid", bus.ext_rvalid, 1);
        check("ct_rdata", bus.ext_rdata, init_val(8'h20));
        check("ct_cpu_back", bus.cpu_stall, 0);
        check("ct_cpu_rdata", bus.cpu_rdata, init_val(8'h30));
        tick();

        phase = "locked_burst";
        b = 0;
        for (int c = 1; c <= 40 && b < 12; c++) begin
            drive(0, 1, 0, 8'h40, 8'h00, 1, 1, 1, 8'(b), 8'(b) ^ 8'hC3);
            check("bu_gnt", bus.ext_gnt, (c >= 5 && c <= 12) || (c >= 17 && c <= 20));
            if (bus.ext_gnt) b++;
            tick();
        end
        check("bu_beats", b, 12);
        drive(0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 8'h00);
        tick();

        phase = "lock_drop";
        b = 0;
        for (int c = 1; c <= 20 && b < 4; c++) begin
            drive(0, 1, 0, 8'h41, 8'h00, 1, 1, (b < 3), 8'h50 + 8'(b), 8'h70 + 8'(b));
            if (b == 3) check("ld_final_beat", bus.ext_gnt, 1);
            if (bus.ext_gnt) b++;
            tick();
        end
        check("ld_beats", b, 4);
        check("ld_state_idle", 32'(dut.state), 32'(1'(ARB_IDLE)));
        drive(0, 1, 0, 8'h41, 8'h00, 1, 1, 0, 8'h54, 8'h74);
        check("ld_cpu_next_gnt", bus.ext_gnt, 0);
        check("ld_cpu_next_stall", bus.cpu_stall, 0);
        tick();
        drive(0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 8'h00);
        tick();

        phase = "reset_mid_burst";
        drive(0, 0, 0, 8'h00, 8'h00, 1, 1, 1, 8'h60, 8'h99);
        check("rb_beat0", bus.ext_gnt, 1);
        tick();
        drive(0, 0, 0, 8'h00, 8'h00, 1, 0, 1, 8'h61, 8'h00);
        check("rb_beat1", bus.ext_gnt, 1);
        tick();
        drive(1, 0, 0, 8'h00, 8'h00, 1, 1, 1, 8'h62, 8'h5C);
        check("rb_rvalid_pre", bus.ext_rvalid, 1);
        tick();
        drive(0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 8'h00);
        check("rb_rvalid", bus.ext_rvalid, 0);
        check("rb_state", 32'(dut.state), 32'(1'(ARB_IDLE)));
        check("rb_burst_cnt", 32'(dut.burst_cnt), 0);
        check("rb_mem60", mem[8'h60], 8'h99);
        check("rb_mem62", mem[8'h62], init_val(8'h62));
        tick();

        phase = "random";
        e_req = 0; e_we = 0; e_lock = 0; e_addr = 0; e_wd = 0; last_eg = 0;
        for (int c = 0; c < 600; c++) begin
            rst   = ($urandom_range(0, 79) == 0);
            creq  = 1'($urandom_range(0, 1));
            cwe   = 1'($urandom_range(0, 1));
            caddr = 8'($urandom_range(0, 31));
            cwd   = 8'($urandom);
            if (!e_req || last_eg) begin
                e_req  = ($urandom_range(0, 3) != 0);
                e_we   = 1'($urandom_range(0, 1));
                e_lock = ($urandom_range(0, 2) != 0);
                e_addr = 8'($urandom_range(0, 31));
                e_wd   = 8'($urandom);
            end
            drive(rst, creq, cwe, caddr, cwd, e_req, e_we, e_lock, e_addr, e_wd);
            last_eg = p_eg;
            tick();
        end

        phase = "final";
        diffs = 0;
        for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) diffs++;
        check("mem_image_diffs", diffs, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
Single-port arbiter that shares the 8-bit data memory between the core's load/store path (cpu) and an external loader/debug port (ext). It performs at most one memory access per cycle and stalls the core when ext owns the memory. A starvation counter guarantees ext progress, and a locked-burst mode gives ext a bounded run of back-to-back accesses. It sits between the core datapath and the data memory.

Parameters:
AW, 8, address width
DW, 8, data width
MAX_WAIT, 4, consecutive cycles ext may be denied before it is forced in; legal range 1..15
MAX_BURST, 8, maximum beats in one locked ext burst; legal range 1..15

Ports:
clk  in  1  clock, all state updates on posedge
reset  in  1  synchronous, active-high
cpu_req  in  1  core requests a memory access this cycle
cpu_we  in  1  1 = store, 0 = load
cpu_addr  in  AW  core address
cpu_wdata  in  DW  core store data
cpu_stall  out  1  core access not performed this cycle; core must hold its PC and request
cpu_rdata  out  DW  load data, same cycle (combinational)
ext_req  in  1  ext requests an access
ext_we  in  1  ext write enable
ext_lock  in  1  request a locked burst
ext_addr  in  AW  ext address
ext_wdata  in  DW  ext write data
ext_gnt  out  1  ext access performed this cycle
ext_rdata  out  DW  registered read data
ext_rvalid  out  1  ext_rdata valid; asserted one cycle after a granted ext read
mem_wr_en  out  1  to memory wr_en
mem_addr  out  AW  to memory addr
mem_dat_in  out  DW  to memory dat_in
mem_dat_out  in  DW  from memory; asynchronous read, valid in the same cycle as mem_addr

Behaviour:
- Registered state:
  - state: ARB_IDLE or ARB_EXT_BURST
  - wait_cnt: 0..MAX_WAIT, saturating
  - burst_cnt: 0..MAX_BURST-1
  - ext_rdata, ext_rvalid
- Reset: state=ARB_IDLE, wait_cnt=0, burst_cnt=0, ext_rdata=0, ext_rvalid=0.
- While reset=1, ext_gnt, cpu_stall and mem_wr_en are forced to 0.
- Grant rules, combinational from registered state and current inputs:
  - ARB_EXT_BURST: ext_gnt = ext_req.
  - ARB_IDLE: ext_gnt = ext_req & (!cpu_req | wait_cnt==MAX_WAIT).
  - cpu_gnt = cpu_req & !ext_gnt.
  - cpu_stall = cpu_req & ext_gnt.
- Memory mux:
  - cpu_gnt: mem_addr=cpu_addr, mem_dat_in=cpu_wdata, mem_wr_en=cpu_we.
  - ext_gnt: the same fields from ext.
  - No grant: mem_addr=0, mem_dat_in=0, mem_wr_en=0.
- cpu_rdata = mem_dat_out when cpu_gnt, else 0. Zero-latency loads.
- ext read return: ext_rvalid <= ext_gnt & !ext_we. ext_rdata <= mem_dat_out on that condition, else it holds. No rvalid for writes.
- wait_cnt:
  - cleared when ext_gnt or !ext_req.
  - else incremented, saturating at MAX_WAIT.
- FSM, with the transition evaluated at posedge:
  - ARB_IDLE -> ARB_EXT_BURST when ext_gnt & ext_lock & MAX_BURST>1; burst_cnt <= 1.
  - ARB_EXT_BURST -> ARB_IDLE when any of: !ext_req, !ext_lock, or burst_cnt==MAX_BURST-1 with ext_gnt. On this exit burst_cnt <= 0.
  - An ext_req&!ext_lock cycle in burst is still granted as the final beat.
  - ARB_EXT_BURST, otherwise: stay; burst_cnt increments on each ext_gnt.
- After a burst ends, wait_cnt=0. A pending cpu_req therefore wins the next cycle, so the core is never starved longer than MAX_BURST cycles.
- Simultaneous requests with wait_cnt<MAX_WAIT in ARB_IDLE: cpu wins, ext waits.
- Reset mid-burst returns to ARB_IDLE next cycle. Any pending ext_rvalid is dropped.
- ext must hold its request fields stable while ext_req=1 & ext_gnt=0.

Decomposition:
- Package dmem_arb_pkg:
  - typedef enum logic {ARB_IDLE, ARB_EXT_BURST} arb_state_t
  - constants for default MAX_WAIT and MAX_BURST
- One sub-module: sat_counter (parameterised width and limit; inc, clr, count, at_max). Used for both wait_cnt and burst_cnt.

Test Plan:
- Reset held 2 cycles with cpu_req=1 and ext_req=1 -> ext_gnt=0, cpu_stall=0, mem_wr_en=0, ext_rvalid=0. After release, state ARB_IDLE.
- cpu store alone, addr 0x10, data 0xA5, then load 0x10 -> cycle 1: mem_wr_en=1, addr=0x10, dat=0xA5. Cycle 2: cpu_rdata=0xA5, cpu_stall=0.
- cpu_req and ext_req held continuously (ext read 0x20, ext_lock=0), MAX_WAIT=4 -> cpu granted 4 cycles, ext_gnt on cycle 5 with cpu_stall=1. ext_rvalid=1 on cycle 6 carrying mem[0x20]. Cycle 6 cpu granted again.
- ext locked burst of 12 writes (0x00..0x0B), cpu_req=1 throughout, MAX_BURST=8 -> The burst enters on cycle 5, once wait_cnt saturates. Burst beats 0x00..0x07 are consecutive, each with cpu_stall=1. The next cycle goes to cpu. ext then waits 4 cycles, re-enters, and completes beats 0x08..0x0B.
- ext_lock dropped mid-burst after 3 beats with ext_req=1 -> 4th beat granted as final, FSM returns to ARB_IDLE, pending cpu_req granted next cycle.
- reset asserted during burst beat 2 -> next cycle state ARB_IDLE, ext_rvalid=0, burst_cnt=0. The memory holds only the beats completed before reset.
